// File: rtl/trace_source_arbiter.sv
// -----------------------------------------------------------------------------
// trace_source_arbiter
//
// Purpose: shares the single write port of the trace input buffer between
// NUM_SRC trace sources, one vector per cycle. It arbitrates round-robin
// between sources, and a frame is atomic: once a source's first beat is
// accepted, that source owns the port until its eof beat. A credit counter
// tracks free input-buffer slots, so the buffer is never over-written.
//
// Ports:
//   clk, rst_n     clock and asynchronous active-low reset
//   tracing        global trace enable (gates new frames only)
//   configId/Data  config bus; configId==CONFIG_ID loads the source enable mask
//   req            per-source request, held with its data until granted
//   eof_src        per-source last-beat-of-frame flag
//   vector_src     per-source vectors (NUM_SRC x N x DATA_WIDTH)
//   ib_dequeue     one pulse per vector popped from the input buffer
//   grant          one-hot, combinational; a beat is accepted when req&grant
//   enqueue        registered write strobe to the input buffer
//   vector_out     registered accepted vector
//   eof_out        registered eof of the accepted beat
//   src_id_out     registered id of the accepted source
//   busy           a frame is in progress (LOCKED)
//   overflow_err   sticky; ib_dequeue arrived while all credits were free
//   timeout_err    sticky; a locked owner went idle too long (optional)
//
// Optional feature: define ARB_FRAME_TIMEOUT_EN to add the frame watchdog and
// the timeout_err port. If an owner's req stays low for TIMEOUT_CYCLES locked
// cycles, the lock is released and no synthetic eof is emitted.
// -----------------------------------------------------------------------------
module trace_source_arbiter #(
    parameter int unsigned N              = 8,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned NUM_SRC        = 4,
    parameter int unsigned IB_DEPTH       = 4,
    parameter logic [7:0]  CONFIG_ID      = 8'd3,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         tracing,
    input  logic [7:0]                                   configId,
    input  logic [7:0]                                   configData,
    input  logic [NUM_SRC-1:0]                           req,
    input  logic [NUM_SRC-1:0]                           eof_src,
    input  logic [NUM_SRC-1:0][N-1:0][DATA_WIDTH-1:0]    vector_src,
    input  logic                                         ib_dequeue,
    output logic [NUM_SRC-1:0]                           grant,
    output logic                                         enqueue,
    output logic [N-1:0][DATA_WIDTH-1:0]                 vector_out,
    output logic                                         eof_out,
    output logic [$clog2(NUM_SRC)-1:0]                   src_id_out,
    output logic                                         busy,
    output logic                                         overflow_err
`ifdef ARB_FRAME_TIMEOUT_EN
    ,
    output logic                                         timeout_err
`endif
);

    localparam int unsigned IDW = $clog2(NUM_SRC);
    localparam int unsigned CW  = $clog2(IB_DEPTH + 1);
    localparam logic [CW-1:0] CRED_MAX = CW'(IB_DEPTH - 1);

    typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

    state_t                          r_state;
    logic [IDW-1:0]                  r_rr_ptr;
    logic [IDW-1:0]                  r_owner;
    logic [CW-1:0]                   r_credits;
    logic [NUM_SRC-1:0]              r_mask;
    logic                            r_enqueue;
    logic [N-1:0][DATA_WIDTH-1:0]    r_vector;
    logic                            r_eof;
    logic [IDW-1:0]                  r_src_id;
    logic                            r_overflow;

    logic [NUM_SRC-1:0]              w_elig;
    logic [NUM_SRC-1:0]              w_grant;
    logic [IDW-1:0]                  w_sel;
    logic [IDW-1:0]                  w_idx;
    logic                            w_found;
    logic                            w_accept;

`ifdef ARB_FRAME_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]                   r_to_cnt;
    logic                            r_timeout;
    assign timeout_err = r_timeout;
`endif

    // Mask bits above NUM_SRC are don't-care.
    if (NUM_SRC < 8) begin : g_cfg_unused
        logic w_unused_cfg;
        assign w_unused_cfg = ^configData[7:NUM_SRC];
    end

    // Grant selection. In IDLE the scan runs from the farthest offset down to
    // rr_ptr itself, so the last hit (nearest to rr_ptr) wins without a break.
    always_comb begin
        w_elig  = req & r_mask;
        w_grant = '0;
        w_sel   = '0;
        w_idx   = '0;
        w_found = 1'b0;
        if (r_credits != '0) begin
            if (r_state == ST_LOCKED) begin
                w_sel   = r_owner;
                w_found = 1'b1;
            end else if (tracing) begin
                for (int unsigned k = NUM_SRC; k > 0; k--) begin
                    w_idx = r_rr_ptr + IDW'(k - 1);
                    if (w_elig[w_idx]) begin
                        w_sel   = w_idx;
                        w_found = 1'b1;
                    end
                end
            end
        end
        if (w_found) w_grant[w_sel] = 1'b1;
    end

    assign w_accept = |(req & w_grant);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= '0;
            r_owner    <= '0;
            r_credits  <= CRED_MAX;
            r_mask     <= '1;
            r_enqueue  <= 1'b0;
            r_vector   <= '0;
            r_eof      <= 1'b0;
            r_src_id   <= '0;
            r_overflow <= 1'b0;
`ifdef ARB_FRAME_TIMEOUT_EN
            r_to_cnt   <= '0;
            r_timeout  <= 1'b0;
`endif
        end else begin
            if (configId == CONFIG_ID) r_mask <= configData[NUM_SRC-1:0];

            r_enqueue <= w_accept;
            if (w_accept) begin
                r_vector <= vector_src[w_sel];
                r_eof    <= eof_src[w_sel];
                r_src_id <= w_sel;
            end

            // Simultaneous accept and dequeue cancel out.
            if (w_accept && !ib_dequeue) begin
                r_credits <= r_credits - CW'(1);
            end else if (!w_accept && ib_dequeue) begin
                if (r_credits == CRED_MAX) r_overflow <= 1'b1;
                else                       r_credits  <= r_credits + CW'(1);
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (eof_src[w_sel]) begin
                            r_rr_ptr <= w_sel + IDW'(1);
                        end else begin
                            r_state <= ST_LOCKED;
                            r_owner <= w_sel;
`ifdef ARB_FRAME_TIMEOUT_EN
                            r_to_cnt <= '0;
`endif
                        end
                    end
                end
                ST_LOCKED: begin
                    if (w_accept && eof_src[r_owner]) begin
                        r_state  <= ST_IDLE;
                        r_rr_ptr <= r_owner + IDW'(1);
                    end
`ifdef ARB_FRAME_TIMEOUT_EN
                    else if (w_accept) begin
                        r_to_cnt <= '0;
                    end else if (!req[r_owner]) begin
                        if (r_to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                            r_state   <= ST_IDLE;
                            r_rr_ptr  <= r_owner + IDW'(1);
                            r_timeout <= 1'b1;
                            r_to_cnt  <= '0;
                        end else begin
                            r_to_cnt <= r_to_cnt + TW'(1);
                        end
                    end
`endif
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign grant        = w_grant;
    assign enqueue      = r_enqueue;
    assign vector_out   = r_vector;
    assign eof_out      = r_eof;
    assign src_id_out   = r_src_id;
    assign busy         = (r_state == ST_LOCKED);
    assign overflow_err = r_overflow;

endmodule

// File: tb/tb_trace_source_arbiter.sv
// -----------------------------------------------------------------------------
// tb_trace_source_arbiter
//
// Bench for trace_source_arbiter in its default build. A behavioural model
// (ownership flag, pointer, free-slot count, mask) predicts grant and the
// registered outputs; a negedge process compares every output every cycle.
// Directed scenarios also record the ids of enqueued beats and compare them
// with hand-derived sequences.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_trace_source_arbiter;

    localparam int unsigned N   = 8;
    localparam int unsigned DW  = 32;
    localparam int unsigned NS  = 4;
    localparam int unsigned IBD = 4;
    localparam logic [7:0]  CID = 8'd3;
    localparam int unsigned VW  = N * DW;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic                       tracing = 1'b0;
    logic [7:0]                 configId = '0;
    logic [7:0]                 configData = '0;
    logic [NS-1:0]              req = '0;
    logic [NS-1:0]              eof_src = '0;
    logic [NS-1:0][N-1:0][DW-1:0] vector_src = '0;
    logic                       ib_dequeue = 1'b0;
    logic [NS-1:0]              grant;
    logic                       enqueue;
    logic [N-1:0][DW-1:0]       vector_out;
    logic                       eof_out;
    logic [1:0]                 src_id_out;
    logic                       busy;
    logic                       overflow_err;

    trace_source_arbiter #(
        .N(N), .DATA_WIDTH(DW), .NUM_SRC(NS), .IB_DEPTH(IBD),
        .CONFIG_ID(CID), .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tracing(tracing),
        .configId(configId), .configData(configData),
        .req(req), .eof_src(eof_src), .vector_src(vector_src),
        .ib_dequeue(ib_dequeue), .grant(grant), .enqueue(enqueue),
        .vector_out(vector_out), .eof_out(eof_out), .src_id_out(src_id_out),
        .busy(busy), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit auto_deq = 1'b0;
    int seen[$];
    int exp_seq[$];

    task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_seq(input string nm);
        checks++;
        if (seen.size() != exp_seq.size()) begin
            errors++;
            $display("FAIL %s: got %0d beats expected %0d", nm, seen.size(), exp_seq.size());
        end else begin
            foreach (exp_seq[i]) begin
                if (seen[i] != exp_seq[i]) begin
                    errors++;
                    $display("FAIL %s: beat %0d got src %0d expected src %0d", nm, i, seen[i], exp_seq[i]);
                    break;
                end
            end
        end
    endtask

    // ---------------- behavioural model ----------------
    bit               m_locked;
    int               m_owner, m_ptr, m_cred;
    logic [NS-1:0]    m_mask;
    logic             m_ovf, m_enq, m_eof;
    logic [1:0]       m_id;
    logic [VW-1:0]    m_vec;
    logic [NS-1:0]    m_g;
    int               m_s;

    function automatic void reset_model();
        m_locked = 1'b0; m_owner = 0; m_ptr = 0; m_cred = IBD - 1;
        m_mask = '1; m_ovf = 1'b0; m_enq = 1'b0; m_eof = 1'b0;
        m_id = '0; m_vec = '0;
    endfunction

    function automatic logic [NS-1:0] model_grant();
        logic [NS-1:0] g;
        bit done;
        int s;
        g = '0;
        done = 1'b0;
        if (m_cred > 0) begin
            if (m_locked) begin
                g[m_owner] = 1'b1;
            end else if (tracing) begin
                for (int k = 0; k < NS; k++) begin
                    s = (m_ptr + k) % NS;
                    if (!done && req[s] && m_mask[s]) begin
                        g[s] = 1'b1;
                        done = 1'b1;
                    end
                end
            end
        end
        return g;
    endfunction

    // Inputs change just after posedge, so at negedge they are the values the
    // next edge samples: compare, then advance the model across that edge.
    always @(negedge clk) begin
        if (!rst_n) reset_model();
        m_g = model_grant();
        chk("grant",        VW'(grant),        VW'(m_g));
        chk("busy",         VW'(busy),         VW'(m_locked));
        chk("overflow_err", VW'(overflow_err), VW'(m_ovf));
        chk("enqueue",      VW'(enqueue),      VW'(m_enq));
        chk("eof_out",      VW'(eof_out),      VW'(m_eof));
        chk("src_id_out",   VW'(src_id_out),   VW'(m_id));
        chk("vector_out",   VW'(vector_out),   m_vec);
        if (rst_n) begin
            if (enqueue === 1'b1) seen.push_back(int'(src_id_out));
            m_s = -1;
            for (int i = 0; i < NS; i++) if (m_g[i] && req[i]) m_s = i;
            if (m_s >= 0) begin
                m_enq = 1'b1;
                m_vec = vector_src[m_s];
                m_eof = eof_src[m_s];
                m_id  = 2'(m_s);
                if (eof_src[m_s]) begin
                    m_locked = 1'b0;
                    m_ptr    = (m_s + 1) % NS;
                end else begin
                    m_locked = 1'b1;
                    m_owner  = m_s;
                end
            end else begin
                m_enq = 1'b0;
            end
            if (m_s >= 0 && !ib_dequeue) m_cred--;
            else if (m_s < 0 && ib_dequeue) begin
                if (m_cred == IBD - 1) m_ovf = 1'b1;
                else m_cred++;
            end
            if (configId == CID) m_mask = configData[NS-1:0];
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int s = 0; s < NS; s++)
            for (int l = 0; l < N; l++)
                vector_src[s][l] = {8'(s), 8'(cyc), 8'(l), 8'hA5};
        if (auto_deq) ib_dequeue = enqueue;
    endtask

    task automatic do_reset();
        req = '0; eof_src = '0; ib_dequeue = 1'b0; configId = '0; configData = '0;
        #2 rst_n = 1'b0;
        tick();
        chk("rst_enqueue",  VW'(enqueue),      '0);
        chk("rst_busy",     VW'(busy),         '0);
        chk("rst_overflow", VW'(overflow_err), '0);
        chk("rst_vector",   VW'(vector_out),   '0);
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        tick();
        do_reset();
        tracing = 1'b1;

        // Round-robin fairness, single-beat frames from every source.
        auto_deq = 1'b1;
        seen.delete();
        req = 4'hF; eof_src = 4'hF;
        repeat (5) tick();
        req = '0; eof_src = '0;
        repeat (3) tick();
        exp_seq = {0, 1, 2, 3, 0};
        chk_seq("rr_order");

        // Frame atomicity: src1 three beats, then src2, then src0.
        do_reset();
        auto_deq = 1'b1;
        seen.delete();
        req = 4'b0010; eof_src = 4'b0000; tick();
        chk("busy_locked", VW'(busy), VW'(1));
        req = 4'b0111; tick();
        eof_src = 4'b0010; tick();
        chk("busy_released", VW'(busy), VW'(0));
        req = 4'b0101; eof_src = 4'b0101; tick();
        tick();
        req = '0; eof_src = '0;
        repeat (3) tick();
        exp_seq = {1, 1, 1, 2, 0};
        chk_seq("frame_atomic");

        // Credit backpressure: three slots, then one more per dequeue.
        do_reset();
        auto_deq = 1'b0; ib_dequeue = 1'b0;
        seen.delete();
        req = 4'b0001; eof_src = 4'b0001;
        repeat (6) tick();
        chk("bp_count", VW'(seen.size()), VW'(3));
        chk("bp_grant", VW'(grant), '0);
        ib_dequeue = 1'b1; tick();
        ib_dequeue = 1'b0;
        repeat (4) tick();
        chk("bp_count_after_deq", VW'(seen.size()), VW'(4));
        req = '0; eof_src = '0; tick();

        // Mask: only src1 enabled.
        do_reset();
        auto_deq = 1'b1;
        configId = CID; configData = 8'h02; tick();
        configId = '0; configData = '0;
        seen.delete();
        req = 4'hF; eof_src = 4'hF;
        repeat (4) tick();
        req = '0; eof_src = '0;
        repeat (2) tick();
        exp_seq = {1, 1, 1, 1};
        chk_seq("mask_src1");

        // tracing dropped mid-frame: frame completes, nothing after.
        seen.delete();
        req = 4'b0010; eof_src = 4'b0000; tick();
        tracing = 1'b0; tick();
        eof_src = 4'b0010; tick();
        req = 4'hF; eof_src = 4'hF;
        repeat (4) tick();
        chk("notrace_grant", VW'(grant), '0);
        req = '0; eof_src = '0;
        repeat (2) tick();
        exp_seq = {1, 1, 1};
        chk_seq("tracing_off_frame");
        tracing = 1'b1;

        // Overflow: dequeue with all credits free; sticky, credits saturate.
        do_reset();
        auto_deq = 1'b0;
        ib_dequeue = 1'b1; tick();
        ib_dequeue = 1'b0; tick();
        chk("overflow_set", VW'(overflow_err), VW'(1));
        repeat (3) tick();
        chk("overflow_sticky", VW'(overflow_err), VW'(1));
        seen.delete();
        req = 4'b0001; eof_src = 4'b0001;
        repeat (6) tick();
        req = '0; eof_src = '0;
        repeat (2) tick();
        chk("overflow_saturate", VW'(seen.size()), VW'(3));

        // Asynchronous reset in the middle of a src3 frame.
        do_reset();
        auto_deq = 1'b1;
        req = 4'b1000; eof_src = 4'b0000; tick();
        chk("midframe_busy", VW'(busy), VW'(1));
        chk("midframe_enq",  VW'(enqueue), VW'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("async_enqueue", VW'(enqueue),    '0);
        chk("async_busy",    VW'(busy),       '0);
        chk("async_src_id",  VW'(src_id_out), '0);
        chk("async_eof",     VW'(eof_out),    '0);
        chk("async_vector",  VW'(vector_out), '0);
        req = '0;
        tick(); tick();
        rst_n = 1'b1;
        auto_deq = 1'b0; ib_dequeue = 1'b0;
        seen.delete();
        req = 4'b1001; eof_src = 4'b1001;
        repeat (6) tick();
        req = '0; eof_src = '0;
        repeat (2) tick();
        exp_seq = {0, 3, 0};
        chk_seq("after_reset_credits");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
